// File: rtl/inference_acc_requant.sv
// Bias-seeded accumulator over signed products, requantized (round, shift, saturate) to an activation.
// Optional INFERENCE_ACC_REQUANT_RELU_EN: negative results are forced to zero.
module inference_acc_requant #(
    parameter int IN_WIDTH  = 11,
    parameter int ACC_WIDTH = 20,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 4,
    parameter int MAX_TERMS = 64,
    parameter int CNT_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic [ACC_WIDTH-1:0] bias,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic                 out_err
);
    // state | meaning
    // ACCUM | accepting terms of the current vector
    // HOLD  | result presented, waiting for downstream handshake
    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic signed [ACC_WIDTH:0] RND     = (ACC_WIDTH+1)'(1) << (SHIFT-1);
    localparam logic signed [ACC_WIDTH:0] OUT_MAX = (ACC_WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH:0] OUT_MIN = -OUT_MAX - (ACC_WIDTH+1)'(1);
    localparam logic [ACC_WIDTH-1:0]      ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0]      ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                 state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   acc_sat_seen;

    logic [ACC_WIDTH-1:0]          base;
    logic [ACC_WIDTH:0]            sum_wide;
    logic                          sum_ovf;
    logic [ACC_WIDTH-1:0]          sum;
    logic signed [ACC_WIDTH:0]     round_wide;
    logic signed [ACC_WIDTH:0]     shifted;
    logic [OUT_WIDTH-1:0]          q;
    logic                          clamp;
    logic                          sat_any;
    logic [CNT_WIDTH-1:0]          cnt_inc;
    logic                          by_count;
    logic                          accept;

    assign in_ready = ce & reset & (state == ACCUM);
    assign accept   = in_valid & in_ready;
    assign cnt_inc  = cnt + 1'b1;
    assign by_count = (cnt_inc == CNT_WIDTH'(MAX_TERMS));

    always_comb begin
        base     = (cnt == '0) ? bias : acc;
        sum_wide = {base[ACC_WIDTH-1], base}
                 + {{(ACC_WIDTH+1-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
        sum_ovf  = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
        if (sum_ovf)
            sum = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        else
            sum = sum_wide[ACC_WIDTH-1:0];

        // one guard bit so adding the rounding constant cannot wrap
        round_wide = $signed({sum[ACC_WIDTH-1], sum}) + RND;
        shifted    = round_wide >>> SHIFT;

        q     = shifted[OUT_WIDTH-1:0];
        clamp = 1'b0;
        if (shifted > OUT_MAX) begin
            q     = OUT_MAX[OUT_WIDTH-1:0];
            clamp = 1'b1;
        end else if (shifted < 0) begin
`ifdef INFERENCE_ACC_REQUANT_RELU_EN
            q = '0;
`else
            if (shifted < OUT_MIN) begin
                q     = OUT_MIN[OUT_WIDTH-1:0];
                clamp = 1'b1;
            end
`endif
        end
        sat_any = clamp | sum_ovf | ((cnt != '0) & acc_sat_seen);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ACCUM;
            acc          <= '0;
            cnt          <= '0;
            acc_sat_seen <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_sat      <= 1'b0;
            out_err      <= 1'b0;
        end else if (ce) begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (in_last || by_count) begin
                            out_data     <= q;
                            out_sat      <= sat_any;
                            out_err      <= ~in_last;
                            out_valid    <= 1'b1;
                            cnt          <= '0;
                            acc_sat_seen <= 1'b0;
                            state        <= HOLD;
                        end else begin
                            acc          <= sum;
                            cnt          <= cnt_inc;
                            acc_sat_seen <= sat_any & ~clamp | ((cnt != '0) & acc_sat_seen) | sum_ovf;
                        end
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule
